// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream sources.
// A granted source keeps the UART for a whole frame (until req_last) or until the lock times out.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_transmit,
    output logic [7:0]        uart_tx_byte,
    input  logic              uart_tx_free,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              timeout_evt
);

    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_FREE,
        S_HOLD
    } state_t;

    state_t          state_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [CW-1:0]   lock_cnt_reg;
    logic            last_reg;

    logic [IDW-1:0]  sel;
    logic            found;
    logic [IDW-1:0]  cand;
    logic            ready_en;
    logic [7:0]      data_arr [NREQ];
    logic [7:0]      sel_byte;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign data_arr[gi]  = req_data[8*gi +: 8];
            assign req_ready[gi] = rst && ready_en && (sel == IDW'(gi));
        end
    endgenerate

    // Scan starts just after the last owner so every source gets a turn.
    always_comb begin
        sel   = rr_ptr_reg;
        found = 1'b0;
        cand  = '0;
        if (state_reg == S_HOLD) begin
            sel = grant_id;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(rr_ptr_reg) + k) % NREQ);
                if (!found && req_valid[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    assign ready_en = uart_tx_free &&
                      (((state_reg == S_IDLE) && (|req_valid)) ||
                       ((state_reg == S_HOLD) && req_valid[grant_id]));

    assign sel_byte = data_arr[sel];
    assign busy     = (state_reg != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= IDW'(NREQ - 1);
            lock_cnt_reg  <= '0;
            last_reg      <= 1'b0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
            grant_id      <= '0;
            timeout_evt   <= 1'b0;
        end else begin
            uart_transmit <= 1'b0;
            timeout_evt   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (ready_en) begin
                        uart_tx_byte  <= sel_byte;
                        grant_id      <= sel;
                        last_reg      <= req_last[sel];
                        uart_transmit <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!uart_tx_free) begin
                        state_reg <= S_WAIT_FREE;
                    end
                end
                S_WAIT_FREE: begin
                    if (uart_tx_free) begin
                        if (last_reg) begin
                            rr_ptr_reg <= grant_id;
                            state_reg  <= S_IDLE;
                        end else begin
                            lock_cnt_reg <= '0;
                            state_reg    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // An owner byte arriving on the expiry cycle still wins.
                    if (ready_en) begin
                        uart_tx_byte  <= sel_byte;
                        last_reg      <= req_last[sel];
                        uart_transmit <= 1'b1;
                        lock_cnt_reg  <= '0;
                        state_reg     <= S_ISSUE;
                    end else if (lock_cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
                        timeout_evt <= 1'b1;
                        rr_ptr_reg  <= grant_id;
                        state_reg   <= S_IDLE;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a timed UART model and a frame-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int LT   = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              uart_transmit;
    logic [7:0]        uart_tx_byte;
    logic              uart_tx_free = 1'b1;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              timeout_evt;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_transmit(uart_transmit),
        .uart_tx_byte(uart_tx_byte), .uart_tx_free(uart_tx_free), .grant_id(grant_id),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // requester byte queues: {last, data}
    logic [8:0] rbuf [NREQ][64];
    int rhead [NREQ];
    int rtail [NREQ];
    initial for (int i = 0; i < NREQ; i++) begin rhead[i] = 0; rtail[i] = 0; end

    logic [NREQ-1:0] hs_vec = '0;
    logic uart_pulse_seen = 1'b0;
    logic hold_busy = 1'b0;
    int uframe = 3;
    int ucnt = 0;

    // monitor records
    int cyc = 0;
    logic [7:0] got_q[$];
    int pulse_cyc_q[$];
    int acc_id_q[$];
    int acc_cyc_q[$];
    int to_cnt = 0, to_cyc = 0, free_rise_cyc = 0;
    int proto_err = 0, lock_err = 0;
    int owner = -1;
    logic acc_prev = 1'b0, prev_free = 1'b1;
    logic [7:0] acc_byte = 8'h00, pulse_byte = 8'h00;

    always begin
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_vec[i]) rhead[i]++;
            if (rhead[i] != rtail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rbuf[i][rhead[i] % 64][7:0];
                req_last[i]        = rbuf[i][rhead[i] % 64][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // UART: drops free the cycle after a pulse, keeps it low for uframe cycles
    always begin
        @(posedge clk); #1;
        if (uart_pulse_seen) ucnt = uframe;
        else if (ucnt > 0) ucnt--;
        uart_tx_free = !hold_busy && (ucnt == 0);
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] mask;
        cyc++;
        uart_pulse_seen = uart_transmit;
        if (!rst) begin
            hs_vec = '0; acc_prev = 1'b0; owner = -1; pulse_byte = 8'h00;
            prev_free = uart_tx_free;
        end else begin
            acc = req_valid & req_ready;
            if ($countones(req_ready) > 1) proto_err++;
            if (uart_transmit) begin
                got_q.push_back(uart_tx_byte);
                pulse_cyc_q.push_back(cyc);
                if (!acc_prev || uart_tx_byte !== acc_byte) proto_err++;
                pulse_byte = uart_tx_byte;
            end else if (acc_prev) begin
                proto_err++;
            end
            if (!uart_tx_free && !uart_transmit && uart_tx_byte !== pulse_byte) proto_err++;
            if (timeout_evt) begin to_cnt++; to_cyc = cyc; owner = -1; end
            if (owner >= 0) begin
                mask = '0; mask[owner] = 1'b1;
                if ((req_ready & ~mask) != '0) lock_err++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    acc_id_q.push_back(i);
                    acc_cyc_q.push_back(cyc);
                    acc_byte = req_data[8*i +: 8];
                    owner = req_last[i] ? -1 : i;
                end
            end
            acc_prev = |acc;
            hs_vec = acc;
            if (uart_tx_free && !prev_free) free_rise_cyc = cyc;
            prev_free = uart_tx_free;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        rbuf[i][rtail[i] % 64] = {l, d};
        rtail[i]++;
    endtask

    task automatic reset_assert();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) rtail[i] = rhead[i];
        tick(2);
    endtask

    task automatic reset_release();
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic wait_pulses(input int n, input int budget, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < budget) begin @(posedge clk); c++; end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int c = 0;
        while ((busy || !uart_tx_free) && c < 500) begin @(posedge clk); c++; end
        ok = !busy && uart_tx_free;
        tick(2);
    endtask

    task automatic test_single();
        int bg = got_q.size(), ba = acc_id_q.size();
        bit ok;
        reset_assert();
        uframe = 4;
        load(0, 8'hA5, 1'b1);
        load(0, 8'hA6, 1'b1);
        reset_release();
        wait_pulses(bg + 2, 200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_wait: got %0d pulses, need %0d", got_q.size() - bg, 2); return; end
        wait_idle(ok);
        n_tests++;
        if (acc_id_q[ba] !== 0) begin n_fail++; $display("FAIL single_id: got %0d need 0", acc_id_q[ba]); end
        n_tests++;
        if (got_q[bg] !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %h need a5", got_q[bg]); end
        n_tests++;
        if (pulse_cyc_q[bg] !== acc_cyc_q[ba] + 1) begin n_fail++; $display("FAIL single_latency: pulse %0d accept %0d", pulse_cyc_q[bg], acc_cyc_q[ba]); end
        n_tests++;
        if (acc_cyc_q[ba+1] !== pulse_cyc_q[bg] + uframe + 2) begin n_fail++; $display("FAIL single_next_accept: got cyc %0d need %0d", acc_cyc_q[ba+1], pulse_cyc_q[bg] + uframe + 2); end
        n_tests++;
        if (got_q[bg+1] !== 8'hA6) begin n_fail++; $display("FAIL single_byte2: got %h need a6", got_q[bg+1]); end
        n_tests++;
        if (grant_id !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: grant %0d busy %0b need 0 0", grant_id, busy); end
    endtask

    task automatic test_rr_order();
        logic [7:0] exp [5];
        int bg = got_q.size();
        bit ok;
        exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12; exp[3] = 8'h13; exp[4] = 8'h10;
        reset_assert();
        uframe = 3;
        load(0, 8'h10, 1'b1); load(0, 8'h10, 1'b1);
        load(1, 8'h11, 1'b1); load(2, 8'h12, 1'b1); load(3, 8'h13, 1'b1);
        reset_release();
        wait_pulses(bg + 5, 300, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rr_wait: got %0d pulses need 5", got_q.size() - bg); return; end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (got_q[bg+k] !== exp[k]) begin n_fail++; $display("FAIL rr_byte%0d: got %h need %h", k, got_q[bg+k], exp[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (pulse_cyc_q[bg+k+1] - pulse_cyc_q[bg+k] !== uframe + 3) begin
                n_fail++; $display("FAIL rr_spacing%0d: got %0d need %0d", k, pulse_cyc_q[bg+k+1] - pulse_cyc_q[bg+k], uframe + 3);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_lock_frame();
        logic [7:0] exp [5];
        int bg = got_q.size(), ba = acc_id_q.size(), bl = lock_err;
        int c = 0;
        bit ok;
        exp[0] = 8'h21; exp[1] = 8'h22; exp[2] = 8'h23; exp[3] = 8'h33; exp[4] = 8'h11;
        reset_assert();
        uframe = 2;
        load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h23, 1'b1);
        reset_release();
        while (acc_id_q.size() <= ba && c < 50) begin @(posedge clk); c++; end
        load(1, 8'h11, 1'b1);
        load(3, 8'h33, 1'b1);
        wait_pulses(bg + 5, 300, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL lock_wait: got %0d pulses need 5", got_q.size() - bg); return; end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (got_q[bg+k] !== exp[k]) begin n_fail++; $display("FAIL lock_byte%0d: got %h need %h", k, got_q[bg+k], exp[k]); end
        end
        n_tests++;
        if (lock_err !== bl) begin n_fail++; $display("FAIL lock_foreign_ready: got %0d cycles need 0", lock_err - bl); end
        wait_idle(ok);
    endtask

    task automatic test_reset();
        reset_assert();
        load(0, 8'h5A, 1'b1);
        load(2, 8'h5B, 1'b1);
        tick(2); #3;
        n_tests++;
        if (req_ready !== 4'b0000 || req_valid !== 4'b0101) begin n_fail++; $display("FAIL reset_ready: ready %b valid %b need 0000 0101", req_ready, req_valid); end
        n_tests++;
        if (uart_transmit !== 1'b0 || busy !== 1'b0 || timeout_evt !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: transmit %b busy %b timeout %b need 0 0 0", uart_transmit, busy, timeout_evt);
        end
        n_tests++;
        if (grant_id !== 2'd0 || uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_regs: grant %0d byte %h need 0 00", grant_id, uart_tx_byte); end
        for (int i = 0; i < NREQ; i++) rtail[i] = rhead[i];
        tick(2);
        reset_release();
        tick(2);
    endtask

    task automatic test_timeout();
        int bg = got_q.size(), ba = acc_id_q.size(), bt = to_cnt;
        bit ok;
        reset_assert();
        uframe = 3;
        load(1, 8'h55, 1'b0);
        load(2, 8'h66, 1'b1);
        reset_release();
        wait_pulses(bg + 2, 300, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL to_wait: got %0d pulses need 2", got_q.size() - bg); return; end
        wait_idle(ok);
        tick(20);
        n_tests++;
        if (acc_id_q[ba] !== 1 || acc_id_q[ba+1] !== 2 || acc_id_q.size() !== ba + 2) begin
            n_fail++; $display("FAIL to_order: got %0d,%0d (%0d accepts) need 1,2 (2)", acc_id_q[ba], acc_id_q[ba+1], acc_id_q.size() - ba);
        end
        n_tests++;
        if (to_cnt - bt !== 1) begin n_fail++; $display("FAIL to_pulse_cycles: got %0d need 1", to_cnt - bt); end
        n_tests++;
        if (to_cyc !== pulse_cyc_q[bg] + uframe + 2 + LT) begin n_fail++; $display("FAIL to_time: got cyc %0d need %0d", to_cyc, pulse_cyc_q[bg] + uframe + 2 + LT); end
        n_tests++;
        if (acc_cyc_q[ba+1] !== to_cyc || got_q[bg+1] !== 8'h66) begin
            n_fail++; $display("FAIL to_next: accept cyc %0d byte %h need %0d 66", acc_cyc_q[ba+1], got_q[bg+1], to_cyc);
        end
    endtask

    task automatic test_reset_midframe();
        int bg = got_q.size(), ba, pc;
        bit ok;
        reset_assert();
        uframe = 8;
        for (int i = 0; i < NREQ; i++) load(i, 8'h40 + 8'(i), 1'b1);
        reset_release();
        wait_pulses(bg + 1, 100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_wait: no pulse"); return; end
        pc = pulse_cyc_q[bg];
        tick(3); #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (uart_transmit !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset: transmit %b busy %b ready %b need 0 0 0000", uart_transmit, busy, req_ready);
        end
        for (int i = 0; i < NREQ; i++) rtail[i] = rhead[i];
        tick(2);
        for (int i = 0; i < NREQ; i++) load(i, 8'h30 + 8'(i), 1'b1);
        ba = acc_id_q.size();
        bg = got_q.size();
        reset_release();
        wait_pulses(bg + 1, 100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_wait2: no pulse after reset"); return; end
        n_tests++;
        if (acc_id_q[ba] !== 0 || got_q[bg] !== 8'h30) begin n_fail++; $display("FAIL mid_first: id %0d byte %h need 0 30", acc_id_q[ba], got_q[bg]); end
        n_tests++;
        if (acc_cyc_q[ba] < pc + uframe + 1) begin n_fail++; $display("FAIL mid_waits_free: accept cyc %0d need >= %0d", acc_cyc_q[ba], pc + uframe + 1); end
        wait_pulses(bg + 4, 300, ok);
        wait_idle(ok);
    endtask

    task automatic test_free_held();
        int bg = got_q.size(), ba = acc_id_q.size();
        bit ok;
        reset_assert();
        uframe = 3;
        hold_busy = 1'b1;
        load(0, 8'h77, 1'b1);
        reset_release();
        tick(10); #3;
        n_tests++;
        if (req_ready !== 4'b0000 || acc_id_q.size() !== ba || got_q.size() !== bg) begin
            n_fail++; $display("FAIL held_no_accept: ready %b accepts %0d pulses %0d need 0000 0 0", req_ready, acc_id_q.size() - ba, got_q.size() - bg);
        end
        hold_busy = 1'b0;
        wait_pulses(bg + 1, 50, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL held_wait: no pulse after free"); return; end
        n_tests++;
        if (acc_cyc_q[ba] !== free_rise_cyc || pulse_cyc_q[bg] !== free_rise_cyc + 1 || got_q[bg] !== 8'h77) begin
            n_fail++; $display("FAIL held_release: accept %0d pulse %0d byte %h need %0d %0d 77", acc_cyc_q[ba], pulse_cyc_q[bg], got_q[bg], free_rise_cyc, free_rise_cyc + 1);
        end
        wait_idle(ok);
    endtask

    task automatic test_random();
        int nfr [NREQ];
        int flen [NREQ][2];
        logic [7:0] fdat [NREQ][2][3];
        int served [NREQ];
        logic [7:0] exp_q[$];
        int ptr, bg, bt, idx;
        bit ok, found;
        for (int r = 0; r < 6; r++) begin
            exp_q.delete();
            bg = got_q.size();
            bt = to_cnt;
            reset_assert();
            uframe = $urandom_range(1, 5);
            for (int i = 0; i < NREQ; i++) begin
                nfr[i] = $urandom_range(0, 2);
                served[i] = 0;
                for (int f = 0; f < nfr[i]; f++) begin
                    flen[i][f] = $urandom_range(1, 3);
                    for (int b = 0; b < flen[i][f]; b++) begin
                        fdat[i][f][b] = 8'($urandom);
                        load(i, fdat[i][f][b], b == flen[i][f] - 1);
                    end
                end
            end
            // whole frames handed out in round-robin order starting after NREQ-1
            ptr = NREQ - 1;
            found = 1'b1;
            while (found) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ && !found; k++) begin
                    idx = (ptr + k) % NREQ;
                    if (served[idx] < nfr[idx]) begin
                        for (int b = 0; b < flen[idx][served[idx]]; b++) exp_q.push_back(fdat[idx][served[idx]][b]);
                        served[idx]++;
                        ptr = idx;
                        found = 1'b1;
                    end
                end
            end
            reset_release();
            if (exp_q.size() == 0) continue;
            wait_pulses(bg + exp_q.size(), 20 * exp_q.size() + 100, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rand%0d_wait: got %0d pulses need %0d", r, got_q.size() - bg, exp_q.size()); continue; end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_tests++;
                if (got_q[bg+k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h need %h", r, k, got_q[bg+k], exp_q[k]); end
            end
            wait_idle(ok);
            n_tests++;
            if (got_q.size() !== bg + exp_q.size() || to_cnt !== bt) begin
                n_fail++; $display("FAIL rand%0d_extra: pulses %0d timeouts %0d need %0d 0", r, got_q.size() - bg, to_cnt - bt, exp_q.size());
            end
        end
    endtask

    initial begin
        tick(3);
        reset_release();
        tick(2);
        test_single();
        test_rr_order();
        test_lock_frame();
        test_reset();
        test_timeout();
        test_reset_midframe();
        test_free_held();
        test_random();
        n_tests++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL protocol: got %0d violations need 0", proto_err); end
        n_tests++;
        if (lock_err !== 0) begin n_fail++; $display("FAIL lock: got %0d foreign-ready cycles need 0", lock_err); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
